// File: rtl/aes_ctr_sync_manager.sv
// Counter-block sequencer for AES-CTR across several independent channels.
// Each channel pairs an active key/counter with a shadow slot that holds the next key/sync.
module aes_ctr_sync_manager #(
   parameter int  NUM_CH  = 4,
   parameter int  BLOCK_W = 128,
   parameter int  CTR_W   = 32,
   localparam int CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_vld,
   output logic               load_rdy,
   input  logic [CW-1:0]      load_ch,
   input  logic [BLOCK_W-1:0] load_key,
   input  logic [BLOCK_W-1:0] load_sync,
   input  logic               req_vld,
   input  logic [CW-1:0]      req_ch,
   output logic               req_rdy,
   output logic               out_vld,
   input  logic               out_rdy,
   output logic [CW-1:0]      out_ch,
   output logic [BLOCK_W-1:0] out_key,
   output logic [BLOCK_W-1:0] out_ctr_blk,
   output logic [NUM_CH-1:0]  ch_active,
   output logic [NUM_CH-1:0]  sync_req,
   output logic [NUM_CH-1:0]  sync_overlapse_irq,
   input  logic [NUM_CH-1:0]  irq_clr
);

   typedef enum logic [1:0] {ST_EMPTY, ST_ACTIVE, ST_EXHAUSTED} ch_state_t;

   // The shift overflows to zero when CTR_W == BLOCK_W, so the mask becomes all ones.
   localparam logic [BLOCK_W-1:0] ONE      = BLOCK_W'(1);
   localparam logic [BLOCK_W-1:0] CTR_MASK = (ONE << CTR_W) - ONE;

   ch_state_t          state_q   [NUM_CH];
   logic [BLOCK_W-1:0] key_q     [NUM_CH];
   logic [BLOCK_W-1:0] blk_q     [NUM_CH];
   logic [BLOCK_W-1:0] start_q   [NUM_CH];
   logic [BLOCK_W-1:0] sh_key_q  [NUM_CH];
   logic [BLOCK_W-1:0] sh_sync_q [NUM_CH];
   logic [NUM_CH-1:0]  sh_vld_q;
   logic [NUM_CH-1:0]  irq_q;

   logic               load_in_range;
   logic               req_in_range;
   logic               req_wrap;
   logic [BLOCK_W-1:0] req_blk;
   logic [BLOCK_W-1:0] req_blk_nxt;
   logic [NUM_CH-1:0]  irq_set;

   // The active block keeps nonce and counter together; only the masked low field increments.
   always_comb begin
      load_in_range = 32'(load_ch) < 32'(NUM_CH);
      req_in_range  = 32'(req_ch) < 32'(NUM_CH);
      load_rdy      = load_in_range && !sh_vld_q[load_ch];
      req_blk       = blk_q[req_ch];
      req_blk_nxt   = (req_blk & ~CTR_MASK) | ((req_blk + ONE) & CTR_MASK);
      req_wrap      = (req_blk_nxt & CTR_MASK) == start_q[req_ch];
      req_rdy       = req_vld && req_in_range && (state_q[req_ch] == ST_ACTIVE)
                      && (!out_vld || out_rdy);
      irq_set       = '0;
      if (req_rdy && req_wrap) begin
         irq_set[req_ch] = 1'b1;
      end
      ch_active = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_active[i] = (state_q[i] == ST_ACTIVE);
      end
      sync_req           = ~sh_vld_q;
      sync_overlapse_irq = irq_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i]   <= ST_EMPTY;
            key_q[i]     <= '0;
            blk_q[i]     <= '0;
            start_q[i]   <= '0;
            sh_key_q[i]  <= '0;
            sh_sync_q[i] <= '0;
         end
         sh_vld_q    <= '0;
         irq_q       <= '0;
         out_vld     <= 1'b0;
         out_ch      <= '0;
         out_key     <= '0;
         out_ctr_blk <= '0;
      end else begin
         // Promotion looks only at registered shadow_vld, so a fresh load waits one extra edge.
         for (int i = 0; i < NUM_CH; i++) begin
            if (state_q[i] != ST_ACTIVE && sh_vld_q[i]) begin
               key_q[i]    <= sh_key_q[i];
               blk_q[i]    <= sh_sync_q[i];
               start_q[i]  <= sh_sync_q[i] & CTR_MASK;
               state_q[i]  <= ST_ACTIVE;
               sh_vld_q[i] <= 1'b0;
            end
         end
         if (load_vld && load_rdy) begin
            sh_key_q[load_ch]  <= load_key;
            sh_sync_q[load_ch] <= load_sync;
            sh_vld_q[load_ch]  <= 1'b1;
         end
         if (req_rdy) begin
            blk_q[req_ch] <= req_blk_nxt;
            if (req_wrap) begin
               state_q[req_ch] <= ST_EXHAUSTED;
            end
            out_vld     <= 1'b1;
            out_ch      <= req_ch;
            out_key     <= key_q[req_ch];
            out_ctr_blk <= req_blk;
         end else if (out_rdy) begin
            out_vld <= 1'b0;
         end
         irq_q <= (irq_q & ~irq_clr) | irq_set;
      end
   end

endmodule

// File: tb/tb_aes_ctr_sync_manager.sv
// Scoreboard bench: dut index 0 uses a 32-bit counter, index 1 a 2-bit counter for wrap cases.
module tb_aes_ctr_sync_manager;

   typedef struct packed {
      logic [1:0]   ch;
      logic [127:0] key;
      logic [127:0] blk;
   } exp_t;

   localparam logic [127:0] K0 = 128'h2B7E_1516_28AE_D2A6_ABF7_1588_09CF_4F3C;
   localparam logic [127:0] S0 = 128'h0123_4567_89AB_CDEF_0011_2233_FFFF_FFFE;
   localparam logic [127:0] N0 = 128'h0123_4567_89AB_CDEF_0011_2233_0000_0000;
   localparam logic [127:0] K2 = 128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F;
   localparam logic [127:0] S2 = 128'hCAFE_BABE_0000_0000_1111_1111_0000_0010;
   localparam logic [127:0] K3 = 128'h3333_3333_3333_3333_3333_3333_3333_3333;
   localparam logic [127:0] S3 = 128'h4444_4444_4444_4444_4444_4444_0000_0000;
   localparam logic [127:0] KB = 128'hB0B0_B0B0_0000_0000_0000_0000_0000_0001;
   localparam logic [127:0] SB = 128'h1111_2222_3333_4444_5555_6666_7777_7771;
   localparam logic [127:0] KA = 128'hA5A5_A5A5_5A5A_5A5A_A5A5_A5A5_5A5A_5A5A;
   localparam logic [127:0] SA = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;
   localparam logic [127:0] KC = 128'hC0C0_C0C0_1234_1234_C0C0_C0C0_4321_4321;
   localparam logic [127:0] SC = 128'h0BAD_F00D_DEAD_BEEF_1234_5678_9ABC_DEF2;

   logic         clk = 1'b0;
   logic         rst;
   logic         load_vld    [2];
   logic         load_rdy    [2];
   logic [1:0]   load_ch     [2];
   logic [127:0] load_key    [2];
   logic [127:0] load_sync   [2];
   logic         req_vld     [2];
   logic [1:0]   req_ch      [2];
   logic         req_rdy     [2];
   logic         out_vld     [2];
   logic         out_rdy     [2];
   logic [1:0]   out_ch      [2];
   logic [127:0] out_key     [2];
   logic [127:0] out_ctr_blk [2];
   logic [3:0]   ch_active   [2];
   logic [3:0]   sync_req    [2];
   logic [3:0]   irq         [2];
   logic [3:0]   irq_clr     [2];

   exp_t q0[$];
   exp_t q1[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      aes_ctr_sync_manager #(.NUM_CH(4), .BLOCK_W(128), .CTR_W((g == 0) ? 32 : 2)) dut (
         .clk(clk), .rst(rst),
         .load_vld(load_vld[g]), .load_rdy(load_rdy[g]), .load_ch(load_ch[g]),
         .load_key(load_key[g]), .load_sync(load_sync[g]),
         .req_vld(req_vld[g]), .req_ch(req_ch[g]), .req_rdy(req_rdy[g]),
         .out_vld(out_vld[g]), .out_rdy(out_rdy[g]), .out_ch(out_ch[g]),
         .out_key(out_key[g]), .out_ctr_blk(out_ctr_blk[g]),
         .ch_active(ch_active[g]), .sync_req(sync_req[g]),
         .sync_overlapse_irq(irq[g]), .irq_clr(irq_clr[g])
      );
   end

   task automatic check_output(input string name, input int d, input logic [127:0] act,
                               input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL dut%0d %s: got %h, required %h", d, name, act, exp);
      end
   endtask

   task automatic mon_check(input int d);
      exp_t e;
      if (out_vld[d] && out_rdy[d]) begin
         if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL dut%0d spurious_block: got out_ctr_blk=%h, required none",
                     d, out_ctr_blk[d]);
         end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            check_output("out_ch", d, 128'(out_ch[d]), 128'(e.ch));
            check_output("out_key", d, out_key[d], e.key);
            check_output("out_ctr_blk", d, out_ctr_blk[d], e.blk);
         end
      end
   endtask

   // Monitors pop the scoreboard whenever a block is handed downstream.
   always @(negedge clk) mon_check(0);
   always @(negedge clk) mon_check(1);

   task automatic apply_load(input int d, input int ch, input logic [127:0] key,
                             input logic [127:0] sync);
      load_vld[d]  = 1'b1;
      load_ch[d]   = 2'(ch);
      load_key[d]  = key;
      load_sync[d] = sync;
      @(negedge clk);
      check_output("load_rdy", d, 128'(load_rdy[d]), 128'(1'b1));
      @(posedge clk);
      #1;
      load_vld[d] = 1'b0;
   endtask

   task automatic apply_req(input int d, input int ch, input logic acc,
                            input logic [127:0] key, input logic [127:0] blk);
      exp_t e;
      req_vld[d] = 1'b1;
      req_ch[d]  = 2'(ch);
      if (acc) begin
         e.ch  = 2'(ch);
         e.key = key;
         e.blk = blk;
         if (d == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
      @(negedge clk);
      check_output("req_rdy", d, 128'(req_rdy[d]), 128'(acc));
      @(posedge clk);
      #1;
   endtask

   task automatic apply_idle(input int d);
      req_vld[d] = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         load_vld[d] = 1'b0; load_ch[d] = '0; load_key[d] = '0; load_sync[d] = '0;
         req_vld[d] = 1'b1;  req_ch[d] = '0;  out_rdy[d] = 1'b1; irq_clr[d] = '0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check_output("rst_load_rdy", d, 128'(load_rdy[d]), 128'(1'b1));
         check_output("rst_req_rdy", d, 128'(req_rdy[d]), 128'(1'b0));
         check_output("rst_out_vld", d, 128'(out_vld[d]), 128'(1'b0));
         check_output("rst_ch_active", d, 128'(ch_active[d]), 128'(4'h0));
         check_output("rst_sync_req", d, 128'(sync_req[d]), 128'(4'hF));
         check_output("rst_irq", d, 128'(irq[d]), 128'(4'h0));
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      req_vld[0] = 1'b0;
      req_vld[1] = 1'b0;

      // 32-bit counter wraps without disturbing the nonce.
      apply_load(0, 0, K0, S0);
      check_output("shadow_sync_req", 0, 128'(sync_req[0]), 128'(4'b1110));
      apply_req(0, 0, 1'b0, '0, '0);
      check_output("promoted_active", 0, 128'(ch_active[0]), 128'(4'b0001));
      apply_req(0, 0, 1'b1, K0, N0 | 128'hFFFF_FFFE);
      apply_req(0, 0, 1'b1, K0, N0 | 128'hFFFF_FFFF);
      apply_req(0, 0, 1'b1, K0, N0);
      apply_idle(0);

      // Interleaved channels keep independent counters.
      apply_load(0, 2, K2, S2);
      apply_req(0, 2, 1'b0, '0, '0);
      apply_req(0, 0, 1'b1, K0, N0 | 128'h1);
      apply_req(0, 2, 1'b1, K2, S2);
      apply_req(0, 0, 1'b1, K0, N0 | 128'h2);
      apply_idle(0);

      // Downstream stall: output held, no new accepts, counter frozen.
      out_rdy[0] = 1'b0;
      apply_req(0, 0, 1'b1, K0, N0 | 128'h3);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_output("stall_req_rdy", 0, 128'(req_rdy[0]), 128'(1'b0));
         check_output("stall_out_vld", 0, 128'(out_vld[0]), 128'(1'b1));
         check_output("stall_out_blk", 0, out_ctr_blk[0], N0 | 128'h3);
         @(posedge clk);
         #1;
      end
      out_rdy[0] = 1'b1;
      apply_req(0, 0, 1'b1, K0, N0 | 128'h4);
      apply_req(0, 0, 1'b1, K0, N0 | 128'h5);
      apply_idle(0);

      // 2-bit counter exhausts after four blocks.
      apply_load(1, 0, KB, SB);
      apply_req(1, 0, 1'b0, '0, '0);
      apply_req(1, 0, 1'b1, KB, 128'h1111_2222_3333_4444_5555_6666_7777_7771);
      apply_req(1, 0, 1'b1, KB, 128'h1111_2222_3333_4444_5555_6666_7777_7772);
      apply_req(1, 0, 1'b1, KB, 128'h1111_2222_3333_4444_5555_6666_7777_7773);
      apply_req(1, 0, 1'b1, KB, 128'h1111_2222_3333_4444_5555_6666_7777_7770);
      check_output("exhaust_irq", 1, 128'(irq[1]), 128'(4'b0001));
      check_output("exhaust_active", 1, 128'(ch_active[1]), 128'(4'b0000));
      apply_req(1, 0, 1'b0, '0, '0);
      apply_idle(1);

      // Shadow load waits while active, then promotes once the channel exhausts.
      apply_load(1, 1, KA, SA);
      apply_req(1, 1, 1'b0, '0, '0);
      apply_req(1, 1, 1'b1, KA, SA);
      apply_idle(1);
      apply_load(1, 1, KC, SC);
      check_output("held_sync_req", 1, 128'(sync_req[1]), 128'(4'b1101));
      check_output("held_active", 1, 128'(ch_active[1]), 128'(4'b0010));
      check_output("held_load_rdy", 1, 128'(load_rdy[1]), 128'(1'b0));
      apply_req(1, 1, 1'b1, KA, 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6979);
      apply_req(1, 1, 1'b1, KA, 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_697A);
      irq_clr[1] = 4'b0010;
      apply_req(1, 1, 1'b1, KA, 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_697B);
      irq_clr[1] = 4'b0000;
      check_output("set_beats_clr", 1, 128'(irq[1]), 128'(4'b0011));
      check_output("wrap_active", 1, 128'(ch_active[1]), 128'(4'b0000));
      apply_req(1, 1, 1'b0, '0, '0);
      apply_req(1, 1, 1'b1, KC, SC);
      apply_idle(1);
      check_output("new_key_active", 1, 128'(ch_active[1]), 128'(4'b0010));
      check_output("new_key_sync_req", 1, 128'(sync_req[1]), 128'(4'hF));
      irq_clr[1] = 4'b0001;
      @(posedge clk);
      #1;
      irq_clr[1] = 4'b0000;
      check_output("irq_clr", 1, 128'(irq[1]), 128'(4'b0010));

      // Reset with a pending block and a full shadow discards both.
      out_rdy[0]   = 1'b0;
      req_vld[0]   = 1'b1;
      req_ch[0]    = 2'd0;
      load_vld[0]  = 1'b1;
      load_ch[0]   = 2'd3;
      load_key[0]  = K3;
      load_sync[0] = S3;
      @(negedge clk);
      check_output("pre_rst_req_rdy", 0, 128'(req_rdy[0]), 128'(1'b1));
      check_output("pre_rst_load_rdy", 0, 128'(load_rdy[0]), 128'(1'b1));
      @(posedge clk);
      #1;
      req_vld[0]  = 1'b0;
      load_vld[0] = 1'b0;
      check_output("pre_rst_out_vld", 0, 128'(out_vld[0]), 128'(1'b1));
      check_output("pre_rst_shadow", 0, 128'(load_rdy[0]), 128'(1'b0));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      req_vld[0] = 1'b1;
      check_output("post_rst_out_vld", 0, 128'(out_vld[0]), 128'(1'b0));
      check_output("post_rst_load_rdy", 0, 128'(load_rdy[0]), 128'(1'b1));
      check_output("post_rst_irq", 1, 128'(irq[1]), 128'(4'h0));
      check_output("post_rst_active", 1, 128'(ch_active[1]), 128'(4'h0));
      check_output("post_rst_sync_req", 0, 128'(sync_req[0]), 128'(4'hF));
      @(negedge clk);
      check_output("post_rst_req_rdy", 0, 128'(req_rdy[0]), 128'(1'b0));
      @(posedge clk);
      #1;
      check_output("post_rst_no_block", 0, 128'(out_vld[0]), 128'(1'b0));
      req_vld[0] = 1'b0;
      out_rdy[0] = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      check_output("q0_pending", 0, 128'(q0.size()), 128'(0));
      check_output("q1_pending", 1, 128'(q1.size()), 128'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
